// File: rtl/scene_pkg.sv
// rtl/scene_pkg.sv - shared types and constants for the scene frame loader
package scene_pkg;

    localparam logic [7:0] SCENE_MAGIC = 8'hA5;

    typedef enum logic [7:0] {
        OP_LOAD = 8'h01,
        OP_CAM  = 8'h02,
        OP_SWAP = 8'h03
    } opcode_e;

    // Upper 24 bits of a header word; the low 40 bits carry no meaning.
    typedef struct packed {
        logic [7:0] magic;
        logic [7:0] opcode;
        logic [7:0] count;
    } scene_hdr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPHERES,
        S_CAMERA,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/scene_frame_loader_if.sv
// rtl/scene_frame_loader_if.sv - word stream in, scene RAM write port out
interface scene_frame_loader_if #(
    parameter int ADDR_W = 4
);
    logic              i_word_dv;
    logic [63:0]       i_word;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [63:0]       o_wr_data;

    modport master (
        output i_word_dv, i_word,
        input  o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        input  i_word_dv, i_word,
        output o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/irq_pulse_gen.sv
// rtl/irq_pulse_gen.sv - retriggerable fixed-length interrupt pulse
module irq_pulse_gen #(
    parameter int IRQ_CYC = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_trig,
    output logic o_irq
);
    localparam int CNT_W = $clog2(IRQ_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A trigger reloads the full length; otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_trig) begin
            cnt_d = CNT_W'(IRQ_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_irq = (cnt_q != '0);

endmodule

// File: rtl/scene_frame_loader.sv
// rtl/scene_frame_loader.sv - parses host word stream into scene RAM writes and camera updates
module scene_frame_loader
    import scene_pkg::*;
#(
    parameter int MAX_OBJ     = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int IRQ_CYC     = 100
) (
    input  logic                 CLK100MHZ,
    input  logic                 ck_rst_,
    scene_frame_loader_if.slave  word_if,
    output logic [63:0]          o_cam_data,
    output logic                 o_cam_dv,
    output logic [ADDR_W:0]      o_obj_count,
    output logic                 o_swap,
    output logic                 o_frame_done,
    output logic                 o_err,
    output logic                 o_irq
);
    localparam int               TMO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       MAX_OBJ_B = 8'(MAX_OBJ);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   obj_count_q, obj_count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [63:0]       wr_data_q, wr_data_d;
    logic [63:0]       cam_data_q, cam_data_d;
    logic              cam_dv_q, cam_dv_d;
    logic              swap_q, swap_d;
    logic              frame_done_q, frame_done_d;

    scene_hdr_t        hdr;
    logic              hdr_bad;
    logic              irq_trig;

    // Header decode, payload routing, drain and idle timeout.
    always_comb begin
        hdr          = word_if.i_word[63:40];
        hdr_bad      = 1'b0;
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        remaining_d  = remaining_q;
        tmo_d        = '0;
        err_d        = err_q;
        obj_count_d  = obj_count_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cam_data_d   = cam_data_q;
        cam_dv_d     = 1'b0;
        swap_d       = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (word_if.i_word_dv) begin
                    if (hdr.magic != SCENE_MAGIC) begin
                        err_d = 1'b1;
                    end else begin
                        case (hdr.opcode)
                            OP_LOAD: begin
                                if (hdr.count == 8'd0) begin
                                    err_d        = 1'b0;
                                    obj_count_d  = '0;
                                    frame_done_d = 1'b1;
                                end else if (hdr.count <= MAX_OBJ_B) begin
                                    err_d   = 1'b0;
                                    idx_d   = '0;
                                    n_d     = hdr.count[ADDR_W:0];
                                    state_d = S_SPHERES;
                                end else begin
                                    hdr_bad = 1'b1;
                                end
                            end
                            OP_CAM: begin
                                if (hdr.count == 8'd1) begin
                                    err_d   = 1'b0;
                                    state_d = S_CAMERA;
                                end else begin
                                    hdr_bad = 1'b1;
                                end
                            end
                            OP_SWAP: begin
                                if (hdr.count == 8'd0) begin
                                    err_d        = 1'b0;
                                    swap_d       = 1'b1;
                                    frame_done_d = 1'b1;
                                end else begin
                                    hdr_bad = 1'b1;
                                end
                            end
                            default: hdr_bad = 1'b1;
                        endcase
                        // A malformed frame still owns its payload words; swallow them.
                        if (hdr_bad) begin
                            err_d = 1'b1;
                            if (hdr.count != 8'd0) begin
                                remaining_d = hdr.count;
                                state_d     = S_DRAIN;
                            end
                        end
                    end
                end
            end
            default: begin
                if (word_if.i_word_dv) begin
                    case (state_q)
                        S_SPHERES: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = idx_q;
                            wr_data_d = word_if.i_word;
                            idx_d     = idx_q + ADDR_W'(1);
                            if (({1'b0, idx_q} + (ADDR_W+1)'(1)) == n_q) begin
                                obj_count_d  = n_q;
                                frame_done_d = 1'b1;
                                state_d      = S_IDLE;
                            end
                        end
                        S_CAMERA: begin
                            cam_data_d   = word_if.i_word;
                            cam_dv_d     = 1'b1;
                            frame_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end
                        S_DRAIN: begin
                            remaining_d = remaining_q - 8'd1;
                            if (remaining_q == 8'd1) begin
                                state_d = S_IDLE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    // Host went quiet mid-frame; abandon it, keep what was written.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
        endcase

        irq_trig = frame_done_d | (err_d & ~err_q);
    end

    // State and output registers.
    always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
        if (!ck_rst_) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            n_q          <= '0;
            remaining_q  <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            obj_count_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cam_data_q   <= '0;
            cam_dv_q     <= 1'b0;
            swap_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            remaining_q  <= remaining_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            obj_count_q  <= obj_count_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cam_data_q   <= cam_data_d;
            cam_dv_q     <= cam_dv_d;
            swap_q       <= swap_d;
            frame_done_q <= frame_done_d;
        end
    end

    irq_pulse_gen #(
        .IRQ_CYC (IRQ_CYC)
    ) u_irq (
        .clk_i  (CLK100MHZ),
        .rst_ni (ck_rst_),
        .i_trig (irq_trig),
        .o_irq  (o_irq)
    );

    assign word_if.o_wr_en   = wr_en_q;
    assign word_if.o_wr_addr = wr_addr_q;
    assign word_if.o_wr_data = wr_data_q;
    assign o_cam_data        = cam_data_q;
    assign o_cam_dv          = cam_dv_q;
    assign o_obj_count       = obj_count_q;
    assign o_swap            = swap_q;
    assign o_frame_done      = frame_done_q;
    assign o_err             = err_q;

endmodule

// File: tb/tb_scene_frame_loader.sv
// tb/tb_scene_frame_loader.sv - self-checking bench for scene_frame_loader
module tb_scene_frame_loader;
    localparam int MAX_OBJ = 16;
    localparam int ADDR_W  = 4;
    localparam int TMO     = 200;
    localparam int IRQ     = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scene_frame_loader_if #(.ADDR_W(ADDR_W)) wif ();
    logic [63:0]     cam_data;
    logic            cam_dv;
    logic [ADDR_W:0] obj_count;
    logic            swap, fd, err, irq;

    scene_frame_loader #(
        .MAX_OBJ(MAX_OBJ), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO), .IRQ_CYC(IRQ)
    ) dut (
        .CLK100MHZ    (clk),
        .ck_rst_      (rst_n),
        .word_if      (wif),
        .o_cam_data   (cam_data),
        .o_cam_dv     (cam_dv),
        .o_obj_count  (obj_count),
        .o_swap       (swap),
        .o_frame_done (fd),
        .o_err        (err),
        .o_irq        (irq)
    );

    typedef struct {
        int npay; int err; int nwr; int fd; int swap; int cam; int obj;
    } exp_t;

    typedef struct {
        logic [63:0] hdr;
        exp_t        e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // event monitor
    int fd_cnt = 0, swap_cnt = 0, cam_cnt = 0, irq_cnt = 0, fd_wr_cnt = 0, swap_fd_cnt = 0;
    logic [ADDR_W+63:0] wr_log[$];
    always @(negedge clk) begin
        if (wif.o_wr_en === 1'b1) wr_log.push_back({wif.o_wr_addr, wif.o_wr_data});
        if (fd === 1'b1)          fd_cnt      <= fd_cnt + 1;
        if (swap === 1'b1)        swap_cnt    <= swap_cnt + 1;
        if (cam_dv === 1'b1)      cam_cnt     <= cam_cnt + 1;
        if (irq === 1'b1)         irq_cnt     <= irq_cnt + 1;
        if (fd === 1'b1 && wif.o_wr_en === 1'b1) fd_wr_cnt   <= fd_wr_cnt + 1;
        if (fd === 1'b1 && swap === 1'b1)        swap_fd_cnt <= swap_fd_cnt + 1;
    end

    int s_fd, s_swap, s_cam, s_irq, s_fdwr, s_swfd, wr_start;
    logic [63:0] pay[$];

    task automatic check(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
        end
    endtask

    function automatic bit all_zero();
        return ({cam_data, cam_dv, obj_count, swap, fd, err, irq,
                 wif.o_wr_en, wif.o_wr_addr, wif.o_wr_data} === '0);
    endfunction

    function automatic exp_t mk(int npay, int e_err, int nwr, int e_fd, int e_sw, int e_cam, int obj);
        exp_t e;
        e.npay = npay; e.err = e_err; e.nwr = nwr; e.fd = e_fd;
        e.swap = e_sw; e.cam = e_cam; e.obj = obj;
        return e;
    endfunction

    // Frame-level reference: outcome of one whole framed command.
    function automatic exp_t model(logic [63:0] h, int cur_obj);
        exp_t e;
        int   n;
        e = mk(0, 1, 0, 0, 0, 0, cur_obj);
        if (h[63:56] != 8'hA5) return e;
        n = int'(h[47:40]);
        e.npay = n;
        case (h[55:48])
            8'h01: if (n <= MAX_OBJ) begin e.err = 0; e.nwr = n; e.fd = 1; e.obj = n; end
            8'h02: if (n == 1) begin e.err = 0; e.cam = 1; e.fd = 1; end
            8'h03: if (n == 0) begin e.err = 0; e.swap = 1; e.fd = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [63:0] w);
        @(negedge clk);
        wif.i_word_dv = 1'b1;
        wif.i_word    = w;
    endtask

    task automatic idle1();
        @(negedge clk);
        wif.i_word_dv = 1'b0;
    endtask

    task automatic run_frame(input logic [63:0] h, input int npay, input int gapmax,
                             input bit use_p0, input logic [63:0] p0);
        s_fd = fd_cnt; s_swap = swap_cnt; s_cam = cam_cnt;
        s_fdwr = fd_wr_cnt; s_swfd = swap_fd_cnt; wr_start = wr_log.size();
        pay.delete();
        put(h);
        for (int i = 0; i < npay; i++) begin
            int          g;
            logic [63:0] w;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (g) idle1();
            w = (use_p0 && i == 0) ? p0 : {$urandom, $urandom};
            pay.push_back(w);
            put(w);
        end
        idle1();
        tick(3);
    endtask

    task automatic check_frame(input string tag, input exp_t e);
        bit ok;
        logic [ADDR_W+63:0] ent;
        check(tag, "err", err, e.err);
        check(tag, "obj_count", obj_count, e.obj);
        check(tag, "writes", wr_log.size() - wr_start, e.nwr);
        check(tag, "frame_done", fd_cnt - s_fd, e.fd);
        check(tag, "swap", swap_cnt - s_swap, e.swap);
        check(tag, "cam_dv", cam_cnt - s_cam, e.cam);
        if (e.nwr > 0) begin
            ok = 1'b1;
            for (int i = 0; i < e.nwr; i++) begin
                if (wr_start + i >= wr_log.size() || i >= pay.size()) begin
                    ok = 1'b0;
                end else begin
                    ent = wr_log[wr_start + i];
                    if (ent[ADDR_W+63:64] != ADDR_W'(i) || ent[63:0] != pay[i]) ok = 1'b0;
                end
            end
            check(tag, "wr_addr_data", ok, 1);
            check(tag, "fd_with_last_wr", fd_wr_cnt - s_fdwr, e.fd);
        end
        if (e.swap > 0) check(tag, "swap_with_fd", swap_fd_cnt - s_swfd, 1);
        if (e.cam > 0)  check(tag, "cam_data", cam_data, pay[0]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        bit   bad;
        int   m_obj;
        exp_t e;

        wif.i_word_dv = 1'b0;
        wif.i_word    = '0;

        // T1: reset held under word traffic
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wif.i_word_dv = 1'b1;
            wif.i_word    = (i == 0) ? 64'hA501_0300_0000_0000 : {$urandom, $urandom};
            #1;
            if (!all_zero()) bad = 1'b1;
        end
        check("T1", "outputs_in_reset", bad, 0);
        @(negedge clk);
        wif.i_word_dv = 1'b0;
        rst_n = 1'b1;
        tick(2);
        check("T1", "outputs_after_release", all_zero(), 1);

        // T2: three-sphere load with IRQ length
        s_irq = irq_cnt;
        run_frame(64'hA501_0300_0000_0000, 3, 0, 1'b0, '0);
        check_frame("T2", mk(3, 0, 3, 1, 0, 0, 3));
        tick(150);
        check("T2", "irq_cycles", irq_cnt - s_irq, IRQ);
        check("T2", "irq_idle", irq, 0);

        // reset in the middle of a frame discards it
        put(64'hA501_0400_0000_0000);
        put({$urandom, $urandom});
        put({$urandom, $urandom});
        bad = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (!all_zero()) bad = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wif.i_word = {$urandom, $urandom};
            #1;
            if (!all_zero()) bad = 1'b1;
        end
        check("RST", "midframe_outputs_zero", bad, 0);
        @(negedge clk);
        wif.i_word_dv = 1'b0;
        rst_n = 1'b1;
        tick(2);

        // T3: oversize load drained, then SWAP clears error
        run_frame(64'hA501_1400_0000_0000, 20, 0, 1'b0, '0);
        check_frame("T3a", mk(20, 1, 0, 0, 0, 0, 0));
        run_frame(64'hA503_0000_0000_0000, 0, 0, 1'b0, '0);
        check_frame("T3b", mk(0, 0, 0, 1, 1, 0, 0));

        // T4: camera word
        run_frame(64'hA502_0100_0000_0000, 1, 0, 1'b1, 64'h1122334455667788);
        check_frame("T4", mk(1, 0, 0, 1, 0, 1, 0));
        check("T4", "cam_literal", cam_data, 64'h1122334455667788);

        // T5: timeout mid-load keeps the prior count
        run_frame(64'hA501_0300_0000_0000, 3, 0, 1'b0, '0);
        check_frame("T5pre", mk(3, 0, 3, 1, 0, 0, 3));
        tick(150);
        run_frame(64'hA501_0400_0000_0000, 2, 0, 1'b0, '0);
        check("T5", "err_before_timeout", err, 0);
        tick(TMO + 50);
        check_frame("T5", mk(2, 1, 2, 0, 0, 0, 3));
        check("T5", "irq_on_timeout", irq, 1);
        run_frame(64'hA503_0000_0000_0000, 0, 0, 1'b0, '0);
        check_frame("T5post", mk(0, 0, 0, 1, 1, 0, 3));

        // T6: bad magic in idle
        tick(150);
        check("T6", "irq_quiet", irq, 0);
        run_frame(64'h5A01_0300_0000_0000, 0, 0, 1'b0, '0);
        check_frame("T6", mk(0, 1, 0, 0, 0, 0, 3));
        check("T6", "irq_on_err", irq, 1);
        run_frame(64'hA503_0000_0000_0000, 0, 0, 1'b0, '0);
        check_frame("T6post", mk(0, 0, 0, 1, 1, 0, 3));

        // table-driven frames
        tbl[0]  = '{64'hA501_0000_0000_0000, mk(0,  0, 0,  1, 0, 0, 0)};
        tbl[1]  = '{64'hA501_0100_0000_0000, mk(1,  0, 1,  1, 0, 0, 1)};
        tbl[2]  = '{64'hA501_1000_0000_0000, mk(16, 0, 16, 1, 0, 0, 16)};
        tbl[3]  = '{64'hA501_1100_0000_0000, mk(17, 1, 0,  0, 0, 0, 16)};
        tbl[4]  = '{64'hA502_0100_0000_0000, mk(1,  0, 0,  1, 0, 1, 16)};
        tbl[5]  = '{64'hA502_0200_0000_0000, mk(2,  1, 0,  0, 0, 0, 16)};
        tbl[6]  = '{64'hA503_0000_0000_0000, mk(0,  0, 0,  1, 1, 0, 16)};
        tbl[7]  = '{64'hA503_0300_0000_0000, mk(3,  1, 0,  0, 0, 0, 16)};
        tbl[8]  = '{64'hA507_0000_0000_0000, mk(0,  1, 0,  0, 0, 0, 16)};
        tbl[9]  = '{64'hA501_0200_0000_0000, mk(2,  0, 2,  1, 0, 0, 2)};
        tbl[10] = '{64'h0001_0000_0000_0000, mk(0,  1, 0,  0, 0, 0, 2)};
        tbl[11] = '{64'hA502_0000_0000_0000, mk(0,  1, 0,  0, 0, 0, 2)};
        tbl[12] = '{64'hA501_0500_0000_0000, mk(5,  0, 5,  1, 0, 0, 5)};
        tbl[13] = '{64'hA500_0300_0000_0000, mk(3,  1, 0,  0, 0, 0, 5)};
        for (int i = 0; i < 14; i++) begin
            run_frame(tbl[i].hdr, tbl[i].e.npay, 0, 1'b0, '0);
            check_frame($sformatf("V%0d", i), tbl[i].e);
        end
        m_obj = 5;

        // randomized frames against the frame-level model
        for (int k = 0; k < 150; k++) begin
            logic [63:0] h;
            logic [7:0]  mg, op, n;
            int          r;
            mg = 8'hA5;
            if ($urandom_range(0, 99) < 8) begin
                mg = 8'($urandom_range(0, 255));
                if (mg == 8'hA5) mg = 8'h00;
            end
            r = int'($urandom_range(0, 9));
            op = (r < 4) ? 8'h01 : (r < 6) ? 8'h02 : (r < 8) ? 8'h03 : 8'($urandom_range(4, 255));
            r = int'($urandom_range(0, 9));
            n = (r < 2) ? 8'd0 : (r < 4) ? 8'd1 : (r < 8) ? 8'($urandom_range(2, 16)) : 8'($urandom_range(17, 20));
            h = {$urandom, $urandom};
            h[63:40] = {mg, op, n};
            e = model(h, m_obj);
            run_frame(h, e.npay, 2, 1'b0, '0);
            check_frame($sformatf("R%0d", k), e);
            m_obj = e.obj;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
